// File: rtl/rvfi_imem_responder.sv
// Fetch-bus slave for formal and sim harnesses.
// Wait-state handshake, parcel injection, protocol/stall monitors.
module rvfi_imem_responder #(
  parameter int XLEN             = 32,
  parameter int DW               = 32,
  parameter int WAITW            = 3,
  parameter int MAX_WAIT         = 7,
  parameter int STALL_LIMIT      = 16,
  parameter int CHECK_DATA_READS = 0,
  parameter int CNTW             = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [DW-1:0]     mem_wdata,
  input  logic [DW/8-1:0]   mem_wstrb,
  output logic              mem_ready,
  output logic [DW-1:0]     mem_rdata,
  input  logic [XLEN-1:0]   imem_addr,
  input  logic [15:0]       imem_data,
  input  logic [DW-1:0]     free_rdata,
  input  logic [WAITW-1:0]  wait_req,
  output logic              proto_err,
  output logic              stall_err,
  output logic [CNTW-1:0]   fetch_count
);

  localparam int NL   = DW / 16;
  localparam int OFFW = $clog2(DW / 8);
  localparam int SW   = $clog2(STALL_LIMIT + 1);

  localparam logic [WAITW-1:0] MAXW = WAITW'(MAX_WAIT);
  localparam logic [SW-1:0]    SLIM = SW'(STALL_LIMIT);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [WAITW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic               instr_q, instr_d;
  logic [DW/8-1:0]    wstrb_q, wstrb_d;
  logic               proto_q, proto_d;
  logic               stall_err_q, stall_err_d;
  logic [SW-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0]    fcnt_q, fcnt_d;

  logic               viol;
  logic               ovr_ok;
  logic [XLEN-1:0]    base;
  logic               unused_wdata;

  // Write data is only observed by the core-side checker.
  assign unused_wdata = ^mem_wdata;

  // State and bookkeeping registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      instr_q     <= 1'b0;
      wstrb_q     <= '0;
      proto_q     <= 1'b0;
      stall_err_q <= 1'b0;
      stall_cnt_q <= '0;
      fcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      wstrb_q     <= wstrb_d;
      proto_q     <= proto_d;
      stall_err_q <= stall_err_d;
      stall_cnt_q <= stall_cnt_d;
      fcnt_q      <= fcnt_d;
    end
  end

  // Next-state: accept in IDLE, leave WAIT on the ready cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (mem_valid) state_d = S_WAIT;
      S_WAIT: if (cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, wait counter and monitors.
  always_comb begin
    addr_d      = addr_q;
    instr_d     = instr_q;
    wstrb_d     = wstrb_q;
    cnt_d       = cnt_q;
    stall_cnt_d = '0;
    fcnt_d      = fcnt_q;
    viol        = 1'b0;

    if (state_q == S_IDLE && mem_valid) begin
      addr_d  = mem_addr;
      instr_d = mem_instr;
      wstrb_d = mem_wstrb;
      cnt_d   = (wait_req > MAXW) ? MAXW : wait_req;
    end else if (state_q == S_WAIT && cnt_q != '0) begin
      cnt_d = cnt_q - WAITW'(1);
    end

    if (state_q == S_WAIT) begin
      viol = !mem_valid
          || (mem_addr  != addr_q)
          || (mem_instr != instr_q)
          || (mem_wstrb != wstrb_q);
    end
    proto_d = proto_q | viol;

    if (mem_valid && !mem_ready) begin
      if (stall_cnt_q == SLIM) stall_cnt_d = SLIM;
      else stall_cnt_d = stall_cnt_q + SW'(1);
    end
    stall_err_d = stall_err_q | (stall_cnt_d == SLIM);

    if (mem_ready && instr_q && wstrb_q == '0 && fcnt_q != '1) begin
      fcnt_d = fcnt_q + CNTW'(1);
    end
  end

  // Handshake and read data, with per-lane parcel injection.
  always_comb begin
    mem_ready = (state_q == S_WAIT) && (cnt_q == '0);
    mem_rdata = '0;
    base      = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
    ovr_ok    = (wstrb_q == '0) && (instr_q || CHECK_DATA_READS != 0);
    if (mem_ready) begin
      for (int i = 0; i < NL; i++) begin
        if (ovr_ok && (base + XLEN'(2 * i)) == imem_addr)
          mem_rdata[16*i +: 16] = imem_data;
        else
          mem_rdata[16*i +: 16] = free_rdata[16*i +: 16];
      end
    end
  end

  assign proto_err   = proto_q;
  assign stall_err   = stall_err_q;
  assign fetch_count = fcnt_q;

endmodule

// File: tb/tb_rvfi_imem_responder.sv
// Bench for rvfi_imem_responder: 32- and 64-bit instances
// share one request stream; a scoreboard checks read data.
module tb_rvfi_imem_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [63:0] mem_wdata = '0;
  logic [7:0]  mem_wstrb = '0;
  logic [31:0] imem_addr = '0;
  logic [15:0] imem_data = '0;
  logic [63:0] free = '0;
  logic [2:0]  wait_req = '0;

  logic        rdy32, rdy64;
  logic [31:0] rd32;
  logic [63:0] rd64;
  logic        pe32, pe64, se32, se64;
  logic [15:0] fc32, fc64;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  logic [31:0] q32[$];
  logic [63:0] q64[$];

  always #5 clk = ~clk;

  rvfi_imem_responder #(.DW(32), .STALL_LIMIT(4)) u32 (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata[31:0]),
    .mem_wstrb(mem_wstrb[3:0]),
    .mem_ready(rdy32), .mem_rdata(rd32),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .free_rdata(free[31:0]), .wait_req(wait_req),
    .proto_err(pe32), .stall_err(se32), .fetch_count(fc32)
  );

  rvfi_imem_responder #(.DW(64), .STALL_LIMIT(4)) u64 (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ready(rdy64), .mem_rdata(rd64),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .free_rdata(free), .wait_req(wait_req),
    .proto_err(pe64), .stall_err(se64), .fetch_count(fc64)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop an expectation on every ready cycle.
  always @(negedge clk) begin
    if (mon_en && rdy32) begin
      if (q32.size() == 0) chk("spurious_rdy32", 1, 0);
      else chk("rdata32", {32'h0, rd32}, {32'h0, q32.pop_front()});
    end
    if (mon_en && rdy64) begin
      if (q64.size() == 0) chk("spurious_rdy64", 1, 0);
      else chk("rdata64", rd64, q64.pop_front());
    end
  end

  task automatic rst1();
    mem_valid = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic xfer(input logic [31:0] a, input logic ins,
                      input logic [7:0] ws, input int wq,
                      input logic [31:0] ia, input logic [15:0] id,
                      input logic [63:0] fr, input logic [31:0] e32,
                      input logic [63:0] e64, input bit chg);
    int n;
    int lat;
    lat = (wq > 7) ? 7 : wq;
    q32.push_back(e32);
    q64.push_back(e64);
    mem_addr = a; mem_instr = ins; mem_wstrb = ws;
    wait_req = 3'(wq); imem_addr = ia; imem_data = id;
    free = fr; mem_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (chg && n == 1) mem_addr = a + 32'd4;
    end while (!rdy32 && n < 20);
    chk("latency", 64'(n), 64'(lat + 1));
    chk("rdy64_align", {63'h0, rdy64}, 64'h1);
    @(negedge clk);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    mem_wstrb = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    int rc;
    resetn = 1'b0;
    mem_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", {62'h0, rdy32, rdy64}, 64'h0);
    chk("rst_rdata", rd64 | {32'h0, rd32}, 64'h0);
    chk("rst_proto", {62'h0, pe32, pe64}, 64'h0);
    chk("rst_stall", {62'h0, se32, se64}, 64'h0);
    chk("rst_fc", {32'h0, fc32, fc64}, 64'h0);
    mem_valid = 1'b0;
    resetn = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    xfer(32'h100, 1, 8'h00, 0, 32'h102, 16'hBEEF,
         64'h9ABCDEF0_12345678, 32'hBEEF5678,
         64'h9ABCDEF0_BEEF5678, 0);
    chk("fc_t1", {32'h0, fc32, fc64}, {32'h0, 16'd1, 16'd1});
    chk("stall_t1", {62'h0, se32, se64}, 64'h0);

    xfer(32'h20C, 1, 8'h00, 3, 32'h20C, 16'hA5A5,
         64'h1111_2222_3333_4444, 32'h3333_A5A5,
         64'h1111_A5A5_3333_4444, 0);
    chk("fc_t2", {32'h0, fc32, fc64}, {32'h0, 16'd2, 16'd2});
    chk("stall_at_limit", {62'h0, se32, se64}, 64'h3);

    rst1();
    chk("rst2_clear", {30'h0, pe32, pe64, se32, se64, fc32, fc64},
        64'h0);

    chk("proto_pre", {62'h0, pe32, pe64}, 64'h0);
    xfer(32'h40, 1, 8'h00, 2, 32'h300, 16'h1234,
         64'hCAFE_F00D_DEAD_BEEF, 32'hDEAD_BEEF,
         64'hCAFE_F00D_DEAD_BEEF, 1);
    chk("proto_set", {62'h0, pe32, pe64}, 64'h3);
    chk("stall_below", {62'h0, se32, se64}, 64'h0);
    chk("fc_proto", {32'h0, fc32, fc64}, {32'h0, 16'd1, 16'd1});

    xfer(32'h80, 0, 8'h00, 1, 32'h80, 16'h5555,
         64'h0123_4567_89AB_CDEF, 32'h89AB_CDEF,
         64'h0123_4567_89AB_CDEF, 0);
    chk("proto_sticky", {62'h0, pe32, pe64}, 64'h3);
    chk("fc_dread", {32'h0, fc32, fc64}, {32'h0, 16'd1, 16'd1});

    xfer(32'hFFFF_FFFC, 1, 8'h00, 7, 32'hFFFF_FFFE, 16'h7E57,
         64'hAAAA_BBBB_CCCC_DDDD, 32'h7E57_DDDD,
         64'h7E57_BBBB_CCCC_DDDD, 0);
    chk("stall_set", {62'h0, se32, se64}, 64'h3);
    chk("fc_wrap", {32'h0, fc32, fc64}, {32'h0, 16'd2, 16'd2});

    xfer(32'h102, 1, 8'h0F, 0, 32'h102, 16'h9999,
         64'h5A5A_5A5A_0F0F_0F0F, 32'h0F0F_0F0F,
         64'h5A5A_5A5A_0F0F_0F0F, 0);
    chk("fc_write", {32'h0, fc32, fc64}, {32'h0, 16'd2, 16'd2});
    chk("stall_sticky", {62'h0, se32, se64}, 64'h3);

    mem_addr = 32'h60; mem_instr = 1'b1; mem_wstrb = '0;
    wait_req = 3'd5; mem_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst1();
    rc = 0;
    repeat (8) begin
      @(posedge clk); #1;
      rc += int'(rdy32 | rdy64);
    end
    chk("rst_wait_noready", 64'(rc), 64'h0);
    chk("rst_wait_fc", {32'h0, fc32, fc64}, 64'h0);

    xfer(32'h10, 1, 8'h00, 0, 32'h10, 16'h1234,
         64'h0, 32'h0000_1234, 64'h0000_0000_0000_1234, 0);
    chk("fc_after_rst", {32'h0, fc32, fc64}, {32'h0, 16'd1, 16'd1});

    repeat (3) @(posedge clk);
    chk("sb_empty", 64'(q32.size() + q64.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
